mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-side stage feeding the multi-cycle controller: turns ReadM/WriteM/IorD/IRWrite into a
//  registered handshake with the variable-latency memory and latches fetched words into IR or MDR.
//  Supplies opcode/func to the controller and a stall that freezes its state while an access is in flight.
// PARAMETERS
//  WORD_W   16    data/instruction word width
//  ADDR_W   16    memory address width
//  TMO_CYC  255   cycles without mem_ack before the access is aborted and err is set; 0 = never abort
// PORTS
//  clk           in   1       clock, rising edge
//  reset_n       in   1       asynchronous active-low reset
//  read_req      in   1       controller ReadM, sampled only in IDLE
//  write_req     in   1       controller WriteM, sampled only in IDLE
//  i_or_d        in   1       address select: 0 = pc, 1 = alu_out
//  ir_write      in   1       read destination: 1 = IR, 0 = MDR
//  pc            in   ADDR_W  fetch address
//  alu_out       in   ADDR_W  data address
//  wr_data       in   WORD_W  store data (B register)
//  mem_addr      out  ADDR_W  registered memory address
//  mem_wdata     out  WORD_W  registered store data
//  mem_read      out  1       memory read strobe
//  mem_write     out  1       memory write strobe
//  mem_rdata     in   WORD_W  read data, valid in the mem_ack cycle
//  mem_ack       in   1       one-cycle completion pulse from memory
//  ir            out  WORD_W  instruction register
//  mdr           out  WORD_W  memory data register
//  opcode        out  4       ir[15:12]
//  func          out  6       ir[5:0]
//  stall         out  1       high while an access is outstanding; controller must not advance
//  err           out  1       sticky: timeout or simultaneous read+write request
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; mem_read=mem_write=stall=err=0; mem_addr, mem_wdata, ir, mdr = 0.
//  FSM states: IDLE, RD_WAIT, WR_WAIT.
//   IDLE: read_req=1 -> RD_WAIT. Capture mem_addr = i_or_d ? alu_out : pc and the ir_write
//     destination; mem_read=1 from the next cycle.
//     write_req=1 alone -> WR_WAIT. Capture the address and mem_wdata=wr_data; mem_write=1.
//     read_req and write_req together -> read wins, err<=1.
//   RD_WAIT: on mem_ack, write mem_rdata to ir (captured ir_write=1) or mdr (else); mem_read<=0; -> IDLE.
//   WR_WAIT: on mem_ack, mem_write<=0; -> IDLE.
//  stall is combinational: (state!=IDLE) | read_req | write_req in IDLE. It is therefore high in the
//   request cycle and low in the cycle after the ack.
//  Minimum latency: request cycle N, strobe visible N+1, ack at N+1 earliest, ir/mdr valid N+2.
//  mem_addr, mem_wdata and the strobes are stable from the cycle after the request until the ack.
//  mem_ack in IDLE is ignored and causes no register update.
//  Timeout: an 8-bit (clog2-sized) counter clears on entry to a WAIT state and counts each cycle without
//   ack. When it reaches TMO_CYC: drop the strobe, err<=1, -> IDLE; ir and mdr are unchanged.
//  err clears only on reset. ir, mdr, opcode and func hold between accesses.
// STRUCTURE
//  Shared package/header: state encodings and IR field positions (OPC_MSB=15, OPC_LSB=12, FUNC_MSB=5),
//   plus the existing opcode/func defines.
//  One flat module; no sub-module. The timeout counter is inline.
// TESTING
//  1 Fetch: pc=16'h0010, i_or_d=0, ir_write=1, read_req at cycle N, ack at N+3 with rdata=16'hF01C
//    -> mem_addr=0x0010, stall N..N+3, ir=F01C, opcode=F, func=0x1C at N+4.
//  2 Load: alu_out=16'h0042, i_or_d=1, ir_write=0, ack at N+1 with rdata=16'h1234
//    -> mdr=1234 at N+2, ir unchanged, mem_read low at N+2.
//  3 Store: write_req, alu_out=0x0080, wr_data=0xBEEF, ack at N+2
//    -> mem_write held N+1..N+2 with addr/data stable, stall low at N+3.
//  4 Timeout: TMO_CYC=4, read_req, no ack -> strobe drops after 4 wait cycles, err=1, ir/mdr unchanged;
//    a later access still completes normally.
//  5 Conflict and reset: read_req=write_req=1 -> read performed, err=1.
//    reset_n low mid RD_WAIT -> immediate IDLE, strobes 0, err 0; a stray ack after reset is ignored.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access stage: FSM encoding, IR field layout
// and timeout counter sizing.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_e;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
    localparam int OPC_W    = OPC_MSB - OPC_LSB + 1;
    localparam int FUNC_W   = FUNC_MSB - FUNC_LSB + 1;

    // Width of a counter that must hold values 0..tmo inclusive.
    function automatic int tmo_cnt_w(input int tmo);
        return (tmo < 2) ? 1 : $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Registered request / single-pulse acknowledge bus between the access stage
// and a variable-latency memory.
interface mem_access_unit_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multi-cycle core: registers controller requests onto
// the memory bus, latches returned words into IR or MDR and stalls the controller.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TMO_CYC = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                read_req,
    input  logic                write_req,
    input  logic                i_or_d,
    input  logic                ir_write,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [ADDR_W-1:0]   alu_out,
    input  logic [WORD_W-1:0]   wr_data,
    mem_access_unit_if.master   bus,
    output logic [WORD_W-1:0]   ir,
    output logic [WORD_W-1:0]   mdr,
    output logic [OPC_W-1:0]    opcode,
    output logic [FUNC_W-1:0]   func,
    output logic                stall,
    output logic                err
);

    localparam int              CNT_W   = tmo_cnt_w(TMO_CYC);
    localparam logic [CNT_W:0]  TMO_LIM = (CNT_W + 1)'(TMO_CYC);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               tmo_hit;
    logic               start_rd, start_wr, rd_done, set_err;
    logic               dest_ir_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WORD_W-1:0]  wdata_q;
    logic               read_q, write_q;

    // Abort fires on the edge that ends the TMO_CYC-th ack-less wait cycle.
    assign tmo_hit = (TMO_CYC != 0) &&
                     (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == TMO_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: every clocked register uses <= so all flops update from pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d  = state_q;
        start_rd = 1'b0;
        start_wr = 1'b0;
        rd_done  = 1'b0;
        set_err  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (read_req) begin
                    state_d  = ST_RD_WAIT;
                    start_rd = 1'b1;
                    set_err  = write_req;
                end else if (write_req) begin
                    state_d  = ST_WR_WAIT;
                    start_wr = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (bus.mem_ack) begin
                    state_d = ST_IDLE;
                    rd_done = 1'b1;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    set_err = 1'b1;
                end
            end
            ST_WR_WAIT: begin
                if (bus.mem_ack) begin
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    set_err = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // IDLE always precedes a wait state, so clearing in IDLE covers "clear on entry".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            dest_ir_q <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            ir        <= '0;
            mdr       <= '0;
            err       <= 1'b0;
        end else begin
            if (start_rd || start_wr) begin
                addr_q <= i_or_d ? alu_out : pc;
            end
            if (start_rd) begin
                dest_ir_q <= ir_write;
            end
            if (start_wr) begin
                wdata_q <= wr_data;
            end
            read_q  <= (state_d == ST_RD_WAIT);
            write_q <= (state_d == ST_WR_WAIT);
            if (rd_done) begin
                if (dest_ir_q) ir  <= bus.mem_rdata;
                else           mdr <= bus.mem_rdata;
            end
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_read  = read_q;
    assign bus.mem_write = write_q;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign func   = ir[FUNC_MSB:FUNC_LSB];
    assign stall  = (state_q != ST_IDLE) || read_req || write_req;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of single accesses followed by
// hand-written conflict, stray-ack and reset sequences.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        read_req, write_req, i_or_d, ir_write;
    logic [15:0] pc, alu_out, wr_data;
    logic [15:0] ir, mdr;
    logic [3:0]  opcode;
    logic [5:0]  func;
    logic        stall, err;

    int total = 0;
    int bad   = 0;

    mem_access_unit_if #(.WORD_W(16), .ADDR_W(16)) bus_if ();

    mem_access_unit #(.WORD_W(16), .ADDR_W(16), .TMO_CYC(TMO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .read_req  (read_req),
        .write_req (write_req),
        .i_or_d    (i_or_d),
        .ir_write  (ir_write),
        .pc        (pc),
        .alu_out   (alu_out),
        .wr_data   (wr_data),
        .bus       (bus_if),
        .ir        (ir),
        .mdr       (mdr),
        .opcode    (opcode),
        .func      (func),
        .stall     (stall),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic        sel;
        logic        irw;
        logic [15:0] pc;
        logic [15:0] alu;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          ack_at;     // wait cycle carrying the ack; 0 = never
        logic [15:0] exp_addr;
        logic [15:0] exp_ir;
        logic [15:0] exp_mdr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    // Starts at a negedge; returns at the negedge of the first cycle after completion.
    task automatic run_access(input vec_t v);
        bit done;
        @(negedge clk);
        read_req  = v.rd;
        write_req = v.wr;
        i_or_d    = v.sel;
        ir_write  = v.irw;
        pc        = v.pc;
        alu_out   = v.alu;
        wr_data   = v.wdata;
        #1 check("stall_req_cycle", stall, 1'b1);
        @(negedge clk);
        read_req  = 1'b0;
        write_req = 1'b0;
        pc        = 16'hFFFF;
        alu_out   = 16'hFFFF;
        wr_data   = 16'h0000;
        done      = 1'b0;
        for (int c = 1; c <= 8 && !done; c++) begin
            check("wait_read",  bus_if.mem_read,  v.rd);
            check("wait_write", bus_if.mem_write, !v.rd && v.wr);
            check("wait_addr",  bus_if.mem_addr,  v.exp_addr);
            check("wait_stall", stall, 1'b1);
            if (v.wr && !v.rd) check("wait_wdata", bus_if.mem_wdata, v.wdata);
            if (c == v.ack_at) begin
                bus_if.mem_ack   = 1'b1;
                bus_if.mem_rdata = v.rdata;
            end
            @(negedge clk);
            bus_if.mem_ack   = 1'b0;
            bus_if.mem_rdata = 16'h0000;
            if (c == v.ack_at || (v.ack_at == 0 && c == TMO)) done = 1'b1;
        end
        check("done_read",  bus_if.mem_read,  1'b0);
        check("done_write", bus_if.mem_write, 1'b0);
        check("done_stall", stall, 1'b0);
        check("done_ir",    ir,  v.exp_ir);
        check("done_mdr",   mdr, v.exp_mdr);
        check("done_err",   err, v.exp_err);
        check("done_opcode", opcode, v.exp_ir[15:12]);
        check("done_func",   func,   v.exp_ir[5:0]);
    endtask

    initial begin
        //          rd    wr    sel   irw   pc        alu       wdata     rdata     ack addr      ir        mdr       err
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 16'hDEAD, 16'h0000, 16'hF01C, 3, 16'h0010, 16'hF01C, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 16'h0042, 16'h0000, 16'h1234, 1, 16'h0042, 16'hF01C, 16'h1234, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0012, 16'h0080, 16'hBEEF, 16'h0000, 2, 16'h0080, 16'hF01C, 16'h1234, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0013, 16'h0100, 16'h0000, 16'h2A05, 1, 16'h0100, 16'h2A05, 16'h1234, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0014, 16'h0000, 16'h0000, 16'h9999, 0, 16'h0014, 16'h2A05, 16'h1234, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0300, 16'h0000, 16'h5555, 2, 16'h0200, 16'h2A05, 16'h5555, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0400, 16'h0F0F, 16'h0000, 4, 16'h0300, 16'h2A05, 16'h5555, 1'b1};

        reset_n          = 1'b0;
        read_req         = 1'b0;
        write_req        = 1'b0;
        i_or_d           = 1'b0;
        ir_write         = 1'b0;
        pc               = '0;
        alu_out          = '0;
        wr_data          = '0;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = '0;

        repeat (2) @(negedge clk);
        check("rst_ir",    ir, 16'h0000);
        check("rst_mdr",   mdr, 16'h0000);
        check("rst_addr",  bus_if.mem_addr, 16'h0000);
        check("rst_wdata", bus_if.mem_wdata, 16'h0000);
        check("rst_read",  bus_if.mem_read, 1'b0);
        check("rst_write", bus_if.mem_write, 1'b0);
        check("rst_err",   err, 1'b0);
        check("rst_stall", stall, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_access(vecs[i]);

        // Stray ack while idle must not touch ir/mdr.
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 16'hFFFF;
        @(negedge clk);
        bus_if.mem_ack   = 1'b0;
        @(negedge clk);
        check("idle_ack_ir",   ir, 16'h2A05);
        check("idle_ack_mdr",  mdr, 16'h5555);
        check("idle_ack_read", bus_if.mem_read, 1'b0);
        check("idle_ack_stall", stall, 1'b0);

        // Reset clears sticky err.
        reset_n = 1'b0;
        #1 check("rst2_err", err, 1'b0);
        check("rst2_ir", ir, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        // Conflict: read wins, err set.
        read_req = 1'b1; write_req = 1'b1; i_or_d = 1'b1; ir_write = 1'b0;
        alu_out = 16'h0044; wr_data = 16'hAAAA;
        @(negedge clk);
        read_req = 1'b0; write_req = 1'b0;
        check("conf_read",  bus_if.mem_read, 1'b1);
        check("conf_write", bus_if.mem_write, 1'b0);
        check("conf_addr",  bus_if.mem_addr, 16'h0044);
        check("conf_err",   err, 1'b1);
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'h7777;
        @(negedge clk);
        bus_if.mem_ack = 1'b0;
        check("conf_mdr",   mdr, 16'h7777);
        check("conf_ir",    ir, 16'h0000);
        check("conf_stall", stall, 1'b0);

        // Reset in the middle of RD_WAIT, then a stray ack.
        read_req = 1'b1; write_req = 1'b0; i_or_d = 1'b0; ir_write = 1'b1; pc = 16'h0500;
        @(negedge clk);
        read_req = 1'b0;
        check("mid_read_before", bus_if.mem_read, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_read",  bus_if.mem_read, 1'b0);
        check("mid_rst_write", bus_if.mem_write, 1'b0);
        check("mid_rst_stall", stall, 1'b0);
        check("mid_rst_err",   err, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'hABCD;
        @(negedge clk);
        bus_if.mem_ack = 1'b0;
        @(negedge clk);
        check("post_rst_ir",    ir, 16'h0000);
        check("post_rst_mdr",   mdr, 16'h0000);
        check("post_rst_read",  bus_if.mem_read, 1'b0);
        check("post_rst_stall", stall, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
